dm_arbiter: RTL

- Shares the single-port 8-bit data memory between the processor core and a host/debug port. The host port preloads operands and reads results around a program run.
- Sits between the core's load/store path and the data memory inside top_level.
- Per-cycle arbitration: core has fixed priority, with starvation relief for the host.
- Host lock mode holds the memory for multi-cycle host bursts.

---
 rtl/dm_arb_pkg.sv | 18 +
 rtl/dm_arb_starve.sv | 32 +++
 rtl/dm_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types for the data-memory arbiter between the core and the host port.
// Optional statistics counters are enabled by defining DM_ARB_STATS_EN.
package dm_arb_pkg;

    localparam int DM_AW = 8;
    localparam int DM_DW = 8;

    typedef enum logic [0:0] {ARB, HOST_LOCK} arb_state_t;

    typedef struct packed {
        logic             wen;
        logic [DM_AW-1:0] addr;
        logic [DM_DW-1:0] wdata;
    } mem_req_t;

    localparam mem_req_t MEM_IDLE = '0;

endpackage

// File: rtl/dm_arb_starve.sv
// Host starvation counter: counts consecutive denied host cycles, saturating
// at HOST_MAX_WAIT, and flags when the host must win the next arbitration.
module dm_arb_starve #(
    parameter int HOST_MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic host_req,
    input  logic host_gnt,
    input  logic hold,
    output logic starved
);

    localparam logic [3:0] MAX_WAIT = 4'(HOST_MAX_WAIT);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (!hold) begin
            if (host_gnt || !host_req) begin
                cnt <= '0;
            end else if (cnt != MAX_WAIT) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    assign starved = (cnt == MAX_WAIT);

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: core has fixed priority with host starvation relief,
// plus a host lock mode. Define DM_ARB_STATS_EN for transfer statistics.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW            = DM_AW,
    parameter int DW            = DM_DW,
    parameter int HOST_MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_wen,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          host_req,
    input  logic          host_wen,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_lock,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef DM_ARB_STATS_EN
    ,
    output logic [15:0]   stat_core_cnt,
    output logic [15:0]   stat_host_cnt,
    output logic [15:0]   stat_conflict_cnt
`endif
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       starved;
    mem_req_t   sel;

    dm_arb_starve #(
        .HOST_MAX_WAIT(HOST_MAX_WAIT)
    ) u_starve (
        .clk     (clk),
        .reset   (reset),
        .host_req(host_req),
        .host_gnt(host_gnt),
        .hold    (state == HOST_LOCK),
        .starved (starved)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    // Grants are held low for the whole reset cycle.
    always_comb begin
        core_gnt  = 1'b0;
        host_gnt  = 1'b0;
        state_nxt = state;
        if (!reset) begin
            unique case (state)
                ARB: begin
                    if (host_req && starved) begin
                        host_gnt = 1'b1;
                    end else if (core_req) begin
                        core_gnt = 1'b1;
                    end else if (host_req) begin
                        host_gnt = 1'b1;
                    end
                    if (host_gnt && host_lock) begin
                        state_nxt = HOST_LOCK;
                    end
                end
                HOST_LOCK: begin
                    host_gnt = host_req;
                    if (!host_lock) begin
                        state_nxt = ARB;
                    end
                end
                default: state_nxt = ARB;
            endcase
        end
    end

    always_comb begin
        sel = MEM_IDLE;
        if (core_gnt) begin
            sel = '{wen: core_wen, addr: core_addr, wdata: core_wdata};
        end else if (host_gnt) begin
            sel = '{wen: host_wen, addr: host_addr, wdata: host_wdata};
        end
    end

    assign mem_wen   = sel.wen;
    assign mem_addr  = sel.addr;
    assign mem_wdata = sel.wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            core_rvalid <= 1'b0;
            host_rvalid <= 1'b0;
        end else begin
            core_rvalid <= core_req && core_gnt && !core_wen;
            host_rvalid <= host_req && host_gnt && !host_wen;
        end
    end

    assign core_rdata = core_rvalid ? mem_rdata : '0;
    assign host_rdata = host_rvalid ? mem_rdata : '0;

`ifdef DM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_core_cnt     <= '0;
            stat_host_cnt     <= '0;
            stat_conflict_cnt <= '0;
        end else begin
            if (core_req && core_gnt && stat_core_cnt != 16'hFFFF) begin
                stat_core_cnt <= stat_core_cnt + 16'd1;
            end
            if (host_req && host_gnt && stat_host_cnt != 16'hFFFF) begin
                stat_host_cnt <= stat_host_cnt + 16'd1;
            end
            if (core_req && host_req && stat_conflict_cnt != 16'hFFFF) begin
                stat_conflict_cnt <= stat_conflict_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
